mmu_walk_arbiter: RTL
=====================

// Module: mmu_walk_arbiter
// PURPOSE
//  Shares the single page-table walker (translate) between NREQ translation requesters
//  (port 0 = instruction fetch, port 1 = data memory). Round-robin grant, holds the walker
//  until it reports done, returns the PA to the winner as a one-cycle response, and
//  inserts the en-low release cycle the walker needs between walks. Sits in pipeline/memory.
// PARAMETERS
//  NREQ  2   number of requesters (2..4)
//  VA_W  64  virtual/physical address width
// PORTS
//  clk         in   1          clock; all state on posedge
//  reset       in   1          asynchronous, active-low reset
//  req_valid   in   NREQ       per-port request; held high until that port's resp_valid
//  req_va      in   NREQ*VA_W  per-port VA; stable while req_valid high
//  flush       in   1          discard in-flight result, block new grants (satp write/sfence)
//  resp_valid  out  NREQ       one-cycle pulse: translation for that port complete
//  resp_pa     out  VA_W       PA for the port pulsing resp_valid (shared bus)
//  busy        out  1          state != IDLE
//  walk_en     out  1          to translate.en
//  walk_va     out  VA_W       to translate.va
//  walk_done   in   1          from translate.done
//  walk_pa     in   VA_W       from translate.pa
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, rr_ptr=0, resp_valid=0, resp_pa=0, walk_en=0,
//   walk_va=0, drop=0, gnt_id=0. All outputs registered or decoded from registered state.
//  FSM:
//   IDLE: walk_en=0. If flush==0 and any req_valid: winner = first set req_valid at or
//    after rr_ptr (wrapping mod NREQ); latch gnt_id, walk_va<=req_va[gnt_id]; ->WALK.
//    flush==1 -> stay IDLE, no grant.
//   WALK: walk_en=1, walk_va held. drop<=drop|flush each cycle. On walk_done: pa_q<=walk_pa
//    ->RESP. walk_en is never dropped early: walker only exits PTE read on pte_valid, so an
//    aborted walk still runs to completion.
//   RESP: walk_en=0 (mandatory release; walker leaves DONE only on en low).
//    resp_valid[gnt_id]=!(drop|flush), resp_pa=pa_q; rr_ptr<=(gnt_id+1) mod NREQ; drop<=0;
//    ->IDLE.
//  Latency: request seen in IDLE at cycle N -> resp_valid at N+2+W, W = cycles walk_done
//   is low in WALK (W=0 in bare/M-mode where done is combinational with en).
//  Throughput: one translation per 3+W cycles; back-to-back ports alternate.
//  Fairness: a continuously requesting port waits at most NREQ-1 other grants.
//  Simultaneous: all ports valid after reset -> port 0 first. Flush in same cycle as
//   walk_done -> result dropped. Flush in RESP -> pulse suppressed. Flush with new req in
//   IDLE -> no grant that cycle.
//  Requester protocol (asserted in sim, not handled): req_valid must not drop before
//   resp_valid unless flush was high; req_va stable while valid.
//  Dropped requests: after flush, requester re-issues; arbiter keeps no pending queue.
//  Reset mid-walk: FSM returns IDLE immediately; walker is reset by the same reset.
//  rr_ptr width = $clog2(NREQ); wrap computed explicitly, not by overflow (NREQ=3 valid).
// STRUCTURE
//  pipes.sv: typedef enum logic [1:0] {ARB_IDLE, ARB_WALK, ARB_RESP} arb_state_t;
//   localparam MMU_NREQ=2, MMU_PORT_IF=0, MMU_PORT_MEM=1.
//  Sub-module rr_pick (combinational): inputs req vector + rr_ptr, outputs winner id + any.
// TESTING
//  1 bare (satp mode 0): port0 req va=0x8000_1000 at cyc0 -> resp_valid=01 at cyc2,
//    resp_pa=0x8000_1000, walk_en high exactly cyc1.
//  2 Sv39 walk, stubbed PTE mem 3 levels, leaf ppn=0x80002: port1 va=0x4000_0123 ->
//    resp_pa=0x8000_2123, walk_en low in RESP, walker returns to IDLE next cycle.
//  3 both ports valid every cycle, bare, 6 requests -> grants 0,1,0,1,0,1; period 3 cycles.
//  4 flush pulse mid-Sv39 walk on port0 -> walk_en held until walk_done, no resp_valid,
//    busy low 1 cycle after RESP; following port1 request served normally.
//  5 flush and walk_done same cycle -> no response; flush high in IDLE with req -> no grant.
//  6 reset asserted in WALK -> next sample state IDLE, resp_valid=0, walk_en=0, rr_ptr=0.

Source files
------------

// File: rtl/mmu_walk_arbiter_pkg.sv
// Shared types and constants for the page-table-walker arbiter.
package mmu_walk_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_WALK = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_t;

   localparam int MMU_NREQ     = 2;
   localparam int MMU_PORT_IF  = 0;
   localparam int MMU_PORT_MEM = 1;

endpackage

// File: rtl/mmu_walk_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping mod NREQ.
module mmu_walk_arbiter_rr_pick #(
   parameter int NREQ = 2,
   parameter int ID_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] rr_ptr,
   output logic [ID_W-1:0] winner,
   output logic            any
);

   logic [ID_W:0] idx;

   // Wrap is done by explicit subtraction so non-power-of-two NREQ works.
   always_comb begin
      winner = '0;
      any    = 1'b0;
      idx    = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = {1'b0, rr_ptr} + (ID_W+1)'(i);
         if (idx >= (ID_W+1)'(NREQ)) begin
            idx = idx - (ID_W+1)'(NREQ);
         end
         if (!any && req[idx[ID_W-1:0]]) begin
            any    = 1'b1;
            winner = idx[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/mmu_walk_arbiter.sv
// Shares one page-table walker between NREQ requesters with round-robin grant,
// a one-cycle response pulse and a forced walk_en-low release cycle between walks.
module mmu_walk_arbiter
   import mmu_walk_arbiter_pkg::*;
#(
   parameter int NREQ = MMU_NREQ,
   parameter int VA_W = 64,
   localparam int ID_W = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*VA_W-1:0] req_va,
   input  logic                 flush,
   output logic [NREQ-1:0]      resp_valid,
   output logic [VA_W-1:0]      resp_pa,
   output logic                 busy,
   output logic                 walk_en,
   output logic [VA_W-1:0]      walk_va,
   input  logic                 walk_done,
   input  logic [VA_W-1:0]      walk_pa,
   output arb_state_t           dbg_state,
   output logic [ID_W-1:0]      dbg_rr_ptr
);

   // Handshake: a requester raises req_valid with a stable req_va and holds both
   // until its resp_valid pulse; only a flush lets it withdraw early.

   arb_state_t      state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0] gnt_id_q, gnt_id_d;
   logic [VA_W-1:0] walk_va_q, walk_va_d;
   logic [VA_W-1:0] pa_q, pa_d;
   logic            drop_q, drop_d;

   logic [ID_W-1:0] winner;
   logic            any_req;
   logic [VA_W-1:0] va_arr [NREQ];

   for (genvar p = 0; p < NREQ; p++) begin : g_va
      assign va_arr[p] = req_va[p*VA_W +: VA_W];
   end

   mmu_walk_arbiter_rr_pick #(
      .NREQ (NREQ),
      .ID_W (ID_W)
   ) u_rr_pick (
      .req    (req_valid),
      .rr_ptr (rr_ptr_q),
      .winner (winner),
      .any    (any_req)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ARB_IDLE;
         rr_ptr_q  <= '0;
         gnt_id_q  <= '0;
         walk_va_q <= '0;
         pa_q      <= '0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         gnt_id_q  <= gnt_id_d;
         walk_va_q <= walk_va_d;
         pa_q      <= pa_d;
         drop_q    <= drop_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      gnt_id_d  = gnt_id_q;
      walk_va_d = walk_va_q;
      pa_d      = pa_q;
      drop_d    = drop_q;
      case (state_q)
         ARB_IDLE: begin
            if (!flush && any_req) begin
               gnt_id_d  = winner;
               walk_va_d = va_arr[winner];
               state_d   = ARB_WALK;
            end
         end
         // An aborted walk still runs to done; the walker cannot leave a PTE read early.
         ARB_WALK: begin
            drop_d = drop_q | flush;
            if (walk_done) begin
               pa_d    = walk_pa;
               state_d = ARB_RESP;
            end
         end
         ARB_RESP: begin
            rr_ptr_d = (gnt_id_q == ID_W'(NREQ-1)) ? '0 : gnt_id_q + 1'b1;
            drop_d   = 1'b0;
            state_d  = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_comb begin
      resp_valid = '0;
      for (int p = 0; p < NREQ; p++) begin
         resp_valid[p] = (state_q == ARB_RESP) && !(drop_q | flush) && (gnt_id_q == ID_W'(p));
      end
   end

   assign resp_pa    = pa_q;
   assign busy       = (state_q != ARB_IDLE);
   assign walk_en    = (state_q == ARB_WALK);
   assign walk_va    = walk_va_q;
   assign dbg_state  = state_q;
   assign dbg_rr_ptr = rr_ptr_q;

   a_req_held: assert property (@(posedge clk) disable iff (!reset)
      (state_q == ARB_WALK && !drop_q && !flush) |->
         (req_valid[gnt_id_q] && va_arr[gnt_id_q] == walk_va_q));

endmodule
